// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot ROM loader.
package rom_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// Valid/ready word write port from the ROM loader into CPU memory.
interface rom_loader_if;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );

endinterface

// File: rtl/rom_loader_packer.sv
// Little-endian byte-lane assembler: inserts one byte per capture, clears to zero.
module rom_loader_packer
  import rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANE_W-1:0] lane,
  input  logic [7:0]        data,
  input  logic              capture,
  input  logic              clear,
  output logic [31:0]       word
);

  logic [31:0] word_reg;

  // Clear wins over capture so a fresh word never inherits a stale byte.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      word_reg <= '0;
    end else if (capture) begin
      word_reg[{lane, 3'b000} +: 8] <= data;
    end
  end

  assign word = word_reg;

endmodule

// File: rtl/rom_loader.sv
// Boot loader: copies the program ROM into CPU memory as 32-bit words, then releases the CPU.
// Define ROM_LOADER_CHECKSUM_EN to build the running mod-256 byte checksum.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_BYTES = 65536
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [31:0]  rom_address,
  input  logic [7:0]   rom_byte,
  input  logic         rom_done,
  rom_loader_if.master mem,
  output logic         cpu_rst_n,
  output logic         load_complete,
  output logic         load_error,
  output logic [15:0]  word_count,
  output logic [7:0]   checksum
);

  localparam logic [31:0] LIMIT_ADDR = 32'(MAX_BYTES - 1);

  state_t      state_reg, state_next;
  logic [31:0] rom_address_reg;
  logic [15:0] word_count_reg;
  logic        last_reg;
  logic [31:0] buf_word;
  logic        capture, clear, handshake, lane_last, at_limit;

  assign capture   = (state_reg == FETCH);
  assign handshake = (state_reg == WRITE) && mem.mem_ready;
  assign clear     = handshake || ((state_reg == IDLE) && start);
  assign lane_last = (rom_address_reg[LANE_W-1:0] == LANE_W'(WORD_BYTES - 1));
  assign at_limit  = (rom_address_reg == LIMIT_ADDR);

  rom_loader_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .lane    (rom_address_reg[LANE_W-1:0]),
    .data    (rom_byte),
    .capture (capture),
    .clear   (clear),
    .word    (buf_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // rom_done takes priority over the watchdog so a ROM ending exactly at the limit still loads.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      FETCH: begin
        if (rom_done)       state_next = WRITE;
        else if (at_limit)  state_next = ERROR;
        else if (lane_last) state_next = WRITE;
      end
      WRITE:   if (mem.mem_ready) state_next = last_reg ? DONE : FETCH;
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_we     = 1'b0;
    mem.mem_wdata  = '0;
    mem.mem_addr   = BASE_ADDR + 32'({word_count_reg, 2'b00});
    cpu_rst_n      = 1'b0;
    load_complete  = 1'b0;
    load_error     = 1'b0;
    case (state_reg)
      WRITE: begin
        mem.mem_we    = 1'b1;
        mem.mem_wdata = buf_word;
      end
      DONE: begin
        cpu_rst_n     = 1'b1;
        load_complete = 1'b1;
      end
      ERROR:   load_error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_address_reg <= '0;
      word_count_reg  <= '0;
      last_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            rom_address_reg <= '0;
            last_reg        <= 1'b0;
          end
        end
        FETCH: begin
          if (rom_done) begin
            last_reg <= 1'b1;
          end else if (!lane_last && !at_limit) begin
            rom_address_reg <= rom_address_reg + 32'd1;
          end
        end
        WRITE: begin
          if (mem.mem_ready) begin
            if (word_count_reg != 16'hFFFF) word_count_reg <= word_count_reg + 16'd1;
            if (!last_reg) rom_address_reg <= rom_address_reg + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_address = rom_address_reg;
  assign word_count  = word_count_reg;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_reg <= '0;
    end else if (capture) begin
      checksum_reg <= checksum_reg + rom_byte;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected writes queued at start, popped as the memory port accepts them.
`timescale 1ns/1ps
module tb_rom_loader;

  localparam logic [31:0] BASE = 32'h0000_2000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start2;
  logic [31:0] rom_address, rom_address2;
  logic [7:0]  rom_byte, rom_byte2;
  logic        rom_done, rom_done2;
  logic        cpu_rst_n, load_complete, load_error;
  logic        cpu_rst_n2, load_complete2, load_error2;
  logic [15:0] word_count, word_count2;
  logic [7:0]  checksum, checksum2;

  rom_loader_if mif ();
  rom_loader_if mif2 ();

  logic [7:0]  rom_mem [0:63];
  logic [31:0] rom_last;
  assign rom_byte  = rom_mem[rom_address[5:0]];
  assign rom_done  = (rom_address == rom_last);
  assign rom_byte2 = rom_address2[7:0] ^ 8'h5A;
  assign rom_done2 = 1'b0;

  logic stall_en;
  int   stall_cnt;
  logic stall_now;
  assign stall_now     = stall_en && mif.mem_we && (word_count == 16'd1) && (stall_cnt < 3);
  assign mif.mem_ready  = !stall_now;
  assign mif2.mem_ready = 1'b1;

  always @(posedge clk) begin
    if (!stall_en) stall_cnt <= 0;
    else if (stall_now) stall_cnt <= stall_cnt + 1;
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  rom_loader #(.BASE_ADDR(BASE), .MAX_BYTES(65536)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_address(rom_address), .rom_byte(rom_byte), .rom_done(rom_done),
    .mem(mif),
    .cpu_rst_n(cpu_rst_n), .load_complete(load_complete), .load_error(load_error),
    .word_count(word_count), .checksum(checksum)
  );

  rom_loader #(.BASE_ADDR(32'd0), .MAX_BYTES(16)) dut_err (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .rom_address(rom_address2), .rom_byte(rom_byte2), .rom_done(rom_done2),
    .mem(mif2),
    .cpu_rst_n(cpu_rst_n2), .load_complete(load_complete2), .load_error(load_error2),
    .word_count(word_count2), .checksum(checksum2)
  );

  int   checks = 0;
  int   failures = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0] exp_sum;
  int   start_cyc;

  always @(negedge clk) begin
    if (rst_n && mif.mem_we && mif.mem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h", mif.mem_addr, mif.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mif.mem_addr !== mon_e.addr || mif.mem_wdata !== mon_e.data) begin
          failures++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   mif.mem_addr, mif.mem_wdata, mon_e.addr, mon_e.data);
        end else begin
          $display("write addr=%h data=%h ok", mif.mem_addr, mif.mem_wdata);
        end
      end
    end
  end

  int          err_writes = 0;
  logic [31:0] err_last_addr = '0;
  always @(negedge clk) begin
    if (rst_n && mif2.mem_we && mif2.mem_ready) begin
      err_writes++;
      err_last_addr = mif2.mem_addr;
      $display("err_dut write addr=%h data=%h", mif2.mem_addr, mif2.mem_wdata);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Build the expected word stream from the ROM image independently of the DUT.
  task automatic prime(input int len);
    logic [31:0] w;
    w = '0;
    exp_q.delete();
    exp_sum = '0;
    rom_last = 32'(len - 1);
    for (int i = 0; i < len; i++) begin
      if (i % 4 == 0) w = '0;
      w[8*(i%4) +: 8] = rom_mem[i];
      exp_sum = exp_sum + rom_mem[i];
      if (i % 4 == 3 || i == len - 1) exp_q.push_back(wr_t'{addr: BASE + 32'(4*(i/4)), data: w});
    end
  endtask

  task automatic start_load();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cycle;
  endtask

  task automatic wait_done(input int len, input int extra, input string name);
    logic [7:0] want_sum;
    int lat;
    while (!load_complete && (cycle - start_cyc) < 2000) begin
      @(posedge clk); #1;
    end
    lat = cycle - start_cyc;
`ifdef ROM_LOADER_CHECKSUM_EN
    want_sum = exp_sum;
`else
    want_sum = 8'd0;
`endif
    checks++;
    if (load_complete !== 1'b1 || cpu_rst_n !== 1'b1 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL %s_done complete=%b cpu_rst_n=%b error=%b want 1 1 0", name, load_complete, cpu_rst_n, load_error);
    end
    checks++;
    if (lat !== len + (len + 3) / 4 + extra) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, len + (len + 3) / 4 + extra);
    end
    checks++;
    if (word_count !== 16'((len + 3) / 4)) begin
      failures++;
      $display("FAIL %s_word_count got=%0d want=%0d", name, word_count, (len + 3) / 4);
    end
    checks++;
    if (checksum !== want_sum) begin
      failures++;
      $display("FAIL %s_checksum got=%h want=%h", name, checksum, want_sum);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes got=%0d want=0", name, exp_q.size());
    end
    $display("%s: load finished in %0d cycles, words=%0d", name, lat, word_count);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rom_address, mif.mem_we, mif.mem_addr, mif.mem_wdata} !== {32'd0, 1'b0, BASE, 32'd0}) begin
      failures++;
      $display("FAIL reset_bus rom_address=%h we=%b addr=%h wdata=%h", rom_address, mif.mem_we, mif.mem_addr, mif.mem_wdata);
    end
    checks++;
    if ({cpu_rst_n, load_complete, load_error, word_count, checksum} !== {3'b000, 16'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_status cpu_rst_n=%b complete=%b error=%b wc=%0d sum=%h",
               cpu_rst_n, load_complete, load_error, word_count, checksum);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_error();
    int lat;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    start_cyc = cycle;
    while (!load_error2 && (cycle - start_cyc) < 200) begin
      @(posedge clk); #1;
    end
    lat = cycle - start_cyc;
    checks++;
    if (load_error2 !== 1'b1 || lat !== 19) begin
      failures++;
      $display("FAIL error_entry error=%b latency=%0d want 1 19", load_error2, lat);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (err_writes !== 3 || err_last_addr !== 32'h8 || word_count2 !== 16'd3) begin
      failures++;
      $display("FAIL error_writes got=%0d last=%h wc=%0d want 3 00000008 3", err_writes, err_last_addr, word_count2);
    end
    checks++;
    if (cpu_rst_n2 !== 1'b0 || load_complete2 !== 1'b0 || load_error2 !== 1'b1 || mif2.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL error_hold cpu_rst_n=%b complete=%b error=%b we=%b want 0 0 1 0",
               cpu_rst_n2, load_complete2, load_error2, mif2.mem_we);
    end
    $display("error: watchdog tripped after %0d cycles, writes=%0d", lat, err_writes);
  endtask

  task automatic test_full_words();
    do_reset();
    for (int i = 0; i < 32; i++) rom_mem[i] = 8'($urandom);
    prime(32);
    start_load();
    wait_done(32, 0, "full");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (load_complete !== 1'b1 || word_count !== 16'd8 || mif.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL done_absorbs complete=%b wc=%0d we=%b want 1 8 0", load_complete, word_count, mif.mem_we);
    end
  endtask

  task automatic test_partial();
    do_reset();
    for (int i = 0; i < 6; i++) rom_mem[i] = 8'(8'h11 + i);
    prime(6);
    start_load();
    wait_done(6, 0, "partial");
  endtask

  task automatic test_lane0();
    do_reset();
    for (int i = 0; i < 5; i++) rom_mem[i] = 8'(8'hA0 + 3 * i);
    prime(5);
    start_load();
    wait_done(5, 0, "lane0");
  endtask

  task automatic test_stall();
    logic [31:0] a, d, ra;
    int guard;
    do_reset();
    for (int i = 0; i < 32; i++) rom_mem[i] = 8'($urandom);
    prime(32);
    stall_en = 1'b1;
    start_load();
    guard = 0;
    @(negedge clk);
    while (!(mif.mem_we && word_count == 16'd1) && guard < 100) begin
      @(negedge clk); guard++;
    end
    a = mif.mem_addr; d = mif.mem_wdata; ra = rom_address;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mif.mem_we !== 1'b1 || mif.mem_addr !== a || mif.mem_wdata !== d || rom_address !== ra) begin
        failures++;
        $display("FAIL stall_hold%0d we=%b addr=%h data=%h ra=%h want 1 %h %h %h",
                 k, mif.mem_we, mif.mem_addr, mif.mem_wdata, rom_address, a, d, ra);
      end
    end
    wait_done(32, 3, "stall");
    stall_en = 1'b0;
  endtask

  task automatic test_midload_reset();
    int guard;
    do_reset();
    for (int i = 0; i < 32; i++) rom_mem[i] = 8'($urandom);
    prime(32);
    start_load();
    guard = 0;
    @(negedge clk);
    while (!(rom_address == 32'd23 && !mif.mem_we) && guard < 100) begin
      @(negedge clk); guard++;
    end
    @(posedge clk); #1;
    checks++;
    if (mif.mem_we !== 1'b1 || word_count !== 16'd5) begin
      failures++;
      $display("FAIL midreset_in_write we=%b wc=%0d want 1 5", mif.mem_we, word_count);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rom_address, mif.mem_we, mif.mem_addr, mif.mem_wdata, cpu_rst_n, load_complete, load_error, word_count, checksum}
        !== {32'd0, 1'b0, BASE, 32'd0, 3'b000, 16'd0, 8'd0}) begin
      failures++;
      $display("FAIL midreset_outputs ra=%h we=%b addr=%h wdata=%h cpu=%b cmp=%b err=%b wc=%0d sum=%h",
               rom_address, mif.mem_we, mif.mem_addr, mif.mem_wdata, cpu_rst_n, load_complete, load_error, word_count, checksum);
    end
    rst_n = 1'b1;
    prime(32);
    start_load();
    checks++;
    if (rom_address !== 32'd0 || mif.mem_addr !== BASE) begin
      failures++;
      $display("FAIL midreset_restart ra=%h addr=%h want 0 %h", rom_address, mif.mem_addr, BASE);
    end
    wait_done(32, 0, "reload");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; stall_en = 1'b0;
    rom_last = 32'hFFFF_FFFF;
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'h00;
    test_reset();
    test_error();
    test_full_words();
    test_partial();
    test_lane0();
    test_stall();
    test_midload_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
